// File: rtl/rom_fetch_unit.sv
// Fetch stage for the 64x16 microcode ROM: PC, ROM read issue, and a small skid FIFO to the decoder.
// Build option: define ROM_CEN_SKID_EN for a 2-entry FIFO (full-rate under backpressure); default is 1 entry.
module rom_fetch_unit #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              run,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic              ROM_CEN,
    output logic [ADDR_W-1:0] ROM_A,
    input  logic [DATA_W-1:0] ROM_Q,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

`ifdef ROM_CEN_SKID_EN
    localparam logic [1:0] LIMIT = 2'd2;
`else
    localparam logic [1:0] LIMIT = 2'd1;
`endif

    logic [ADDR_W-1:0] pc_r;
    logic              inflight_r;
    logic [ADDR_W-1:0] inflight_pc_r;
    logic [1:0]        occ_r;
    logic [DATA_W-1:0] head_word_r;
    logic [ADDR_W-1:0] head_pc_r;
`ifdef ROM_CEN_SKID_EN
    logic [DATA_W-1:0] tail_word_r;
    logic [ADDR_W-1:0] tail_pc_r;
`endif

    logic              pop_s;
    logic              push_s;
    logic              issue_s;
    logic [1:0]        occ_after_s;
    logic [ADDR_W-1:0] issue_addr_s;

    assign instr_valid = (occ_r != 2'd0);
    assign instr       = head_word_r;
    assign instr_pc    = head_pc_r;

    // Issue decision and ROM request; a jump empties the stage, so it may always issue.
    always_comb begin
        pop_s        = instr_valid & instr_ready;
        push_s       = inflight_r & ~jmp_valid;
        occ_after_s  = 2'd0;
        if (jmp_valid) begin
            occ_after_s = 2'd0;
        end else begin
            occ_after_s = occ_r + {1'b0, inflight_r} - {1'b0, pop_s};
        end
        issue_s      = RSTN & run & (occ_after_s < LIMIT);
        issue_addr_s = jmp_valid ? jmp_addr : pc_r;
        ROM_CEN      = ~issue_s;
        if (issue_s) begin
            ROM_A = issue_addr_s;
        end else begin
            ROM_A = pc_r;
        end
    end

    // Program counter and outstanding-read tracking.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            pc_r          <= {ADDR_W{1'b0}};
            inflight_r    <= 1'b0;
            inflight_pc_r <= {ADDR_W{1'b0}};
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                pc_r          <= issue_addr_s + ADDR_W'(1);
                inflight_pc_r <= issue_addr_s;
            end else if (jmp_valid) begin
                pc_r <= jmp_addr;
            end else begin
                pc_r <= pc_r;
            end
        end
    end

    // Skid FIFO; the head keeps its last contents when the FIFO drains or is flushed.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            occ_r       <= 2'd0;
            head_word_r <= {DATA_W{1'b0}};
            head_pc_r   <= {ADDR_W{1'b0}};
`ifdef ROM_CEN_SKID_EN
            tail_word_r <= {DATA_W{1'b0}};
            tail_pc_r   <= {ADDR_W{1'b0}};
`endif
        end else if (jmp_valid) begin
            occ_r <= 2'd0;
        end else begin
            occ_r <= occ_after_s;
`ifdef ROM_CEN_SKID_EN
            case ({push_s, pop_s})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        head_word_r <= ROM_Q;
                        head_pc_r   <= inflight_pc_r;
                    end else begin
                        tail_word_r <= ROM_Q;
                        tail_pc_r   <= inflight_pc_r;
                    end
                end
                2'b01: begin
                    if (occ_r == 2'd2) begin
                        head_word_r <= tail_word_r;
                        head_pc_r   <= tail_pc_r;
                    end
                end
                2'b11: begin
                    if (occ_r == 2'd1) begin
                        head_word_r <= ROM_Q;
                        head_pc_r   <= inflight_pc_r;
                    end else begin
                        head_word_r <= tail_word_r;
                        head_pc_r   <= tail_pc_r;
                        tail_word_r <= ROM_Q;
                        tail_pc_r   <= inflight_pc_r;
                    end
                end
                default: begin
                    head_word_r <= head_word_r;
                    head_pc_r   <= head_pc_r;
                end
            endcase
`else
            if (push_s) begin
                head_word_r <= ROM_Q;
                head_pc_r   <= inflight_pc_r;
            end
`endif
        end
    end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Self-checking bench for rom_fetch_unit: ROM model, queue-based reference model, directed and random phases.
module tb_rom_fetch_unit;

`ifdef ROM_CEN_SKID_EN
    localparam int LIM = 2;
`else
    localparam int LIM = 1;
`endif

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        run;
    logic        jmp_valid;
    logic [5:0]  jmp_addr;
    logic        ROM_CEN;
    logic [5:0]  ROM_A;
    logic [15:0] ROM_Q;
    logic        instr_valid;
    logic [15:0] instr;
    logic [5:0]  instr_pc;
    logic        instr_ready;

    int checks   = 0;
    int failures = 0;

    logic [15:0] rom [64];

    always #5 CLK = ~CLK;

    rom_fetch_unit #(.ADDR_W(6), .DATA_W(16)) dut (
        .CLK(CLK), .RSTN(RSTN), .run(run), .jmp_valid(jmp_valid), .jmp_addr(jmp_addr),
        .ROM_CEN(ROM_CEN), .ROM_A(ROM_A), .ROM_Q(ROM_Q),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    // Synchronous ROM: data appears the cycle after an enabled read.
    always @(posedge CLK) begin
        if (!ROM_CEN) ROM_Q <= rom[ROM_A];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int word_of(input int pc);
        return 32'hA000 + pc;
    endfunction

    // Reference model: fetch pipeline as a PC, one pending read and a queue of delivered PCs.
    int m_pc = 0;
    bit m_inf = 1'b0;
    int m_inf_pc = 0;
    int m_q[$];
    int m_show_word = 0;
    int m_show_pc = 0;
    bit m_pop;
    bit m_issue;
    int m_after;
    int m_iaddr;

    always @(negedge CLK) begin
        m_pop   = (m_q.size() > 0) && instr_ready;
        m_after = jmp_valid ? 0 : (m_q.size() + int'(m_inf) - int'(m_pop));
        m_issue = RSTN && run && (m_after < LIM);
        m_iaddr = jmp_valid ? int'(jmp_addr) : m_pc;

        check("rom_cen", int'(ROM_CEN), int'(!m_issue));
        check("rom_a", int'(ROM_A), m_issue ? m_iaddr : m_pc);
        check("instr_valid", int'(instr_valid), int'(m_q.size() > 0));
        check("instr", int'(instr), m_show_word);
        check("instr_pc", int'(instr_pc), m_show_pc);
        check("occ_bound", int'(m_q.size() <= LIM), 1);

        if (!RSTN) begin
            m_pc = 0; m_inf = 1'b0; m_inf_pc = 0; m_q.delete();
            m_show_word = 0; m_show_pc = 0;
        end else begin
            if (m_pop) void'(m_q.pop_front());
            if (jmp_valid) m_q.delete();
            else if (m_inf) m_q.push_back(m_inf_pc);
            m_inf = m_issue;
            if (m_issue) begin
                m_inf_pc = m_iaddr;
                m_pc     = (m_iaddr + 1) % 64;
            end else if (jmp_valid) begin
                m_pc = int'(jmp_addr);
            end
            if (m_q.size() > 0) begin
                m_show_pc   = m_q[0];
                m_show_word = word_of(m_q[0]);
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int cnt;
        bit found;
        for (int i = 0; i < 64; i++) rom[i] = 16'hA000 + 16'(i);
        RSTN = 1'b0; run = 1'b0; jmp_valid = 1'b0; jmp_addr = 6'd0; instr_ready = 1'b0;

        repeat (3) begin
            cyc();
            check("rst_valid", int'(instr_valid), 0);
            check("rst_cen", int'(ROM_CEN), 1);
            check("rst_a", int'(ROM_A), 0);
            check("rst_instr", int'(instr), 0);
            check("rst_pc", int'(instr_pc), 0);
        end

        RSTN = 1'b1; run = 1'b1; instr_ready = 1'b1;
        #1;
        check("first_cen", int'(ROM_CEN), 0);
        check("first_a", int'(ROM_A), 0);
        cyc();
        check("lat1_valid", int'(instr_valid), 0);
        cyc();
        check("lat2_valid", int'(instr_valid), 1);
        check("first_instr", int'(instr), 32'hA000);
        check("first_pc", int'(instr_pc), 0);

        cnt = 0;
        repeat (20) begin
            cyc();
            if (instr_valid) cnt++;
        end
        check("throughput", cnt, 10 * LIM);

        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            cyc();
            if (instr_valid && instr_pc == 6'd63) found = 1'b1;
        end
        check("wrap_reach", int'(found), 1);
        cyc();
        for (int k = 0; k < 3 && !instr_valid; k++) cyc();
        check("wrap_pc", int'(instr_pc), 0);
        check("wrap_instr", int'(instr), 32'hA000);

        repeat (5) cyc();
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (k >= 2) check("bp_cen", int'(ROM_CEN), 1);
        end

        jmp_valid = 1'b1; jmp_addr = 6'h20;
        #1;
        check("jmp_cen", int'(ROM_CEN), 0);
        check("jmp_a", int'(ROM_A), 32'h20);
        cyc();
        jmp_valid = 1'b0; jmp_addr = 6'h05; instr_ready = 1'b1;
        check("jmp_bubble", int'(instr_valid), 0);
        cyc();
        check("jmp_valid", int'(instr_valid), 1);
        check("jmp_instr", int'(instr), 32'hA020);
        check("jmp_pc", int'(instr_pc), 32'h20);

        repeat (6) cyc();
        run = 1'b0;
        repeat (4) cyc();
        check("stop_valid", int'(instr_valid), 0);
        check("stop_cen", int'(ROM_CEN), 1);

        run = 1'b1; instr_ready = 1'b0;
        repeat (4) cyc();
        RSTN = 1'b0;
        cyc();
        check("mrst_valid", int'(instr_valid), 0);
        check("mrst_instr", int'(instr), 0);
        RSTN = 1'b1; instr_ready = 1'b1;
        #1;
        check("mrst_cen", int'(ROM_CEN), 0);
        check("mrst_a", int'(ROM_A), 0);
        cyc();
        cyc();
        check("mrst_first_instr", int'(instr), 32'hA000);
        check("mrst_first_pc", int'(instr_pc), 0);

        repeat (3000) begin
            cyc();
            RSTN        = ($urandom_range(0, 199) != 0);
            run         = ($urandom_range(0, 7) != 0);
            instr_ready = ($urandom_range(0, 3) != 0);
            jmp_valid   = ($urandom_range(0, 15) == 0);
            jmp_addr    = 6'($urandom);
        end
        jmp_valid = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
